// File: rtl/nn_rnn_state_buffer.sv
// Recurrent state buffer: counts ones per lane over a 2^CNTW-cycle epoch, latches the
// counts, and regenerates decorrelated unipolar streams from them for the next epoch.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | paused or just reset; a_last forced low
// ST_RUN  | enabled; sampling a_out and regenerating a_last from held
module nn_rnn_state_buffer #(
    parameter int NR   = 4,
    parameter int CNTW = 8
) (
    input  logic            CLK,
    input  logic            INIT,
    input  logic            EN,
    input  logic            SEQ_CLEAR,
    input  logic [NR-1:0]   a_out,
    input  logic [CNTW-1:0] rand_in,
    output logic [NR-1:0]   a_last,
    output logic            epoch_done,
    output logic            state_valid
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_epoch_cnt;
    logic [CNTW:0]   r_acc  [NR];
    logic [CNTW-1:0] r_held [NR];

    logic [CNTW-1:0] w_rot [NR];
    logic [CNTW:0]   w_sum [NR];
    logic [CNTW-1:0] w_sat [NR];
    logic [NR-1:0]   w_regen;
    logic            w_wrap;

    assign w_wrap = &r_epoch_cnt;

    genvar g;
    generate
        for (g = 0; g < NR; g++) begin : g_lane
            localparam int SH = g % CNTW;
            // Per-lane rotation decorrelates lanes sharing one random word.
            if (SH == 0) begin : g_norot
                assign w_rot[g] = rand_in;
            end else begin : g_rot
                assign w_rot[g] = {rand_in[CNTW-1-SH:0], rand_in[CNTW-1:CNTW-SH]};
            end
            assign w_sum[g]   = r_acc[g] + {{CNTW{1'b0}}, a_out[g]};
            assign w_sat[g]   = w_sum[g][CNTW] ? {CNTW{1'b1}} : w_sum[g][CNTW-1:0];
            assign w_regen[g] = r_held[g] > w_rot[g];
        end
    endgenerate

    // Sampling follows EN directly, so the IDLE->RUN cycle is itself a sample and
    // a pause lengthens the epoch by exactly the number of disabled cycles.
    always_ff @(posedge CLK) begin
        if (INIT) begin
            r_state     <= ST_IDLE;
            r_epoch_cnt <= '0;
            a_last      <= '0;
            epoch_done  <= 1'b0;
            state_valid <= 1'b0;
            for (int i = 0; i < NR; i++) begin
                r_acc[i]  <= '0;
                r_held[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: if (EN)  r_state <= ST_RUN;
                ST_RUN:  if (!EN) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase

            a_last     <= {NR{EN}} & w_regen;
            epoch_done <= 1'b0;

            if (SEQ_CLEAR) begin
                r_epoch_cnt <= '0;
                state_valid <= 1'b0;
                for (int i = 0; i < NR; i++) begin
                    r_acc[i]  <= '0;
                    r_held[i] <= '0;
                end
            end else if (EN) begin
                if (w_wrap) begin
                    r_epoch_cnt <= '0;
                    epoch_done  <= 1'b1;
                    state_valid <= 1'b1;
                    for (int i = 0; i < NR; i++) begin
                        r_acc[i]  <= '0;
                        r_held[i] <= w_sat[i];
                    end
                end else begin
                    r_epoch_cnt <= r_epoch_cnt + {{(CNTW-1){1'b0}}, 1'b1};
                    for (int i = 0; i < NR; i++) begin
                        r_acc[i] <= w_sum[i];
                    end
                end
            end
        end
    end

endmodule
